// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exception_ctrl
//  Description : MEM-stage exception/interrupt prioritiser and PC redirect
//                controller. Reports the winning cause to CP0, flushes the
//                pipeline and holds the redirect target until fetch accepts.
//  Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  // MEM-stage instruction
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  // Per-instruction fault flags
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_ld_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  // Live CP0 values
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  // To CP0
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  // Redirect interface
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        newpc_valid_o,
  input  logic        pc_ready_i
);

  localparam logic [31:0] c_code_none    = 32'h0000_0000;
  localparam logic [31:0] c_code_int     = 32'h0000_0001;
  localparam logic [31:0] c_code_adel    = 32'h0000_0004;
  localparam logic [31:0] c_code_ades    = 32'h0000_0005;
  localparam logic [31:0] c_code_syscall = 32'h0000_0008;
  localparam logic [31:0] c_code_break   = 32'h0000_0009;
  localparam logic [31:0] c_code_ri      = 32'h0000_000a;
  localparam logic [31:0] c_code_ov      = 32'h0000_000c;
  localparam logic [31:0] c_code_trap    = 32'h0000_000d;
  localparam logic [31:0] c_code_eret    = 32'h0000_000e;

  // Source of the bad virtual address reported alongside the code
  typedef enum logic [1:0] {
    BADA_NONE = 2'd0,
    BADA_PC   = 2'd1,
    BADA_ADDR = 2'd2
  } bada_sel_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] newpc_q, newpc_d;

  logic        w_int_pend;
  logic [31:0] w_code;
  bada_sel_e   w_bada_sel;
  logic        w_take;

  // Interrupt pending: unmasked request, global enable set, not at exception level
  assign w_int_pend = ((cause_i[15:8] & status_i[15:8]) != 8'h00) &&
                      status_i[0] && !status_i[1];

  // Priority encode the cause; interrupts only attach to a valid idle-state instruction
  always_comb begin
    w_code     = c_code_none;
    w_bada_sel = BADA_NONE;
    if (!rst && mem_valid_i && (state_q == IDLE)) begin
      if (w_int_pend) begin
        w_code = c_code_int;
      end else if (adel_if_i) begin
        w_code     = c_code_adel;
        w_bada_sel = BADA_PC;
      end else if (ri_i) begin
        w_code = c_code_ri;
      end else if (ov_i) begin
        w_code = c_code_ov;
      end else if (trap_i) begin
        w_code = c_code_trap;
      end else if (syscall_i) begin
        w_code = c_code_syscall;
      end else if (break_i) begin
        w_code = c_code_break;
      end else if (adel_ld_i) begin
        w_code     = c_code_adel;
        w_bada_sel = BADA_ADDR;
      end else if (ades_i) begin
        w_code     = c_code_ades;
        w_bada_sel = BADA_ADDR;
      end else if (eret_i) begin
        w_code = c_code_eret;
      end
    end
  end

  assign w_take = (w_code != c_code_none);

  // Next-state and redirect target capture; faults seen in REDIRECT are dropped
  always_comb begin
    state_d = state_q;
    newpc_d = newpc_q;
    case (state_q)
      IDLE: begin
        if (w_take) begin
          state_d = REDIRECT;
          newpc_d = (w_code == c_code_eret) ? epc_i : EXC_VECTOR;
        end
      end
      REDIRECT: begin
        if (pc_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and target registers; reset abandons any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      newpc_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      newpc_q <= newpc_d;
    end
  end

  assign excepttype_o        = w_code;
  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;
  assign bad_addr_o          = (w_bada_sel == BADA_PC)   ? mem_pc_i   :
                               (w_bada_sel == BADA_ADDR) ? mem_addr_i : 32'h0000_0000;

  // Outputs are gated by rst so they read as idle during the reset cycle itself
  assign flush_o       = !rst && (w_take || (state_q == REDIRECT));
  assign newpc_valid_o = !rst && (state_q == REDIRECT);
  assign newpc_o       = rst ? 32'h0000_0000 : newpc_q;

endmodule
`default_nettype wire

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception entry PC.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports mem_valid_i, input, 1; mem_pc_i, input, 32; mem_in_delayslot_i, input, 1. These describe the MEM-stage instruction.
REQ-005 SHALL have per-instruction fault flags, each input, 1: adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_i, eret_i.
REQ-006 SHALL have ports mem_addr_i, input, 32, load/store effective address.
REQ-007 SHALL have ports status_i, cause_i and epc_i, input, 32 each, live CP0 values.
REQ-008 SHALL have output ports excepttype_o, 32; current_inst_addr_o, 32; is_in_delayslot_o, 1; bad_addr_o, 32. These ports feed CP0.
REQ-009 SHALL have output ports flush_o, 1; newpc_o, 32; newpc_valid_o, 1. SHALL have input port pc_ready_i, 1, fetch accepts redirect.

Function
REQ-010 SHALL implement a 2-state FSM: IDLE and REDIRECT.
REQ-011 int_pend SHALL be 1 iff all of the following hold: (cause_i[15:8] & status_i[15:8]) != 0, status_i[0]==1, and status_i[1]==0.
REQ-012 In IDLE with mem_valid_i=1, excepttype_o SHALL be combinational from current inputs, taking the first matching code in this order:
  - int_pend -> 1
  - adel_if_i -> 4
  - ri_i -> 'h0a
  - ov_i -> 'h0c
  - trap_i -> 'h0d
  - syscall_i -> 8
  - break_i -> 9
  - adel_ld_i -> 4
  - ades_i -> 5
  - eret_i -> 'h0e
  - otherwise 0
REQ-013 excepttype_o SHALL be 0 whenever mem_valid_i=0, state=REDIRECT, or rst=1.
REQ-014 current_inst_addr_o SHALL equal mem_pc_i, and is_in_delayslot_o SHALL equal mem_in_delayslot_i, both combinational.
REQ-015 bad_addr_o SHALL be mem_pc_i when the selected code came from adel_if_i. It SHALL be mem_addr_i for adel_ld_i or ades_i, and 0 otherwise.
REQ-016 flush_o SHALL be 1 in any IDLE cycle with nonzero excepttype_o, and 1 throughout REDIRECT.
REQ-017 On a nonzero excepttype_o in IDLE, the FSM SHALL go to REDIRECT at the next posedge and register newpc.
  - code 'h0e: newpc = epc_i
  - any other code: newpc = EXC_VECTOR
REQ-018 newpc_valid_o SHALL be 1 exactly while in REDIRECT, and newpc_o SHALL hold the registered value, stable until accepted.
REQ-019 REDIRECT SHALL return to IDLE at the posedge where pc_ready_i=1. The handshake completes in the cycle newpc_valid_o and pc_ready_i are both 1.
REQ-020 Faults and interrupts presented while in REDIRECT SHALL be ignored, not queued.
REQ-021 Minimum redirect latency SHALL be 1 cycle. The exception is seen in cycle N, newpc_valid_o=1 in cycle N+1, and with pc_ready_i=1 the FSM is back in IDLE in cycle N+2.
REQ-022 When several flags are set together, only the highest-priority code SHALL be reported, and bad_addr_o SHALL follow that code.
REQ-023 An interrupt SHALL attach only to a valid MEM instruction; if int_pend=1 and mem_valid_i=0, no action SHALL be taken.

Reset
REQ-024 While rst=1, the following SHALL hold:
  - FSM is in IDLE
  - newpc_o=0, newpc_valid_o=0, flush_o=0
  - excepttype_o=0, bad_addr_o=0
REQ-025 rst asserted during REDIRECT SHALL abandon the redirect at the next posedge without waiting for pc_ready_i.

Verification
REQ-026 Syscall: mem_valid_i=1, syscall_i=1, mem_pc_i='hBFC00100 -> excepttype_o=8, flush_o=1; next cycle newpc_o='hBFC00380, newpc_valid_o=1.
REQ-027 Load address error: adel_ld_i=1, ov_i=1, mem_addr_i='h00000003 -> excepttype_o='h0c, bad_addr_o=0.
REQ-028 Store address error: ades_i=1 alone, mem_addr_i='h00000003 -> excepttype_o=5, bad_addr_o='h00000003.
REQ-029 Eret with back-pressure: eret_i=1, epc_i='hBFC00500, pc_ready_i=0 for 3 cycles -> newpc_valid_o held 3 cycles at 'hBFC00500, flush_o=1; the posedge with pc_ready_i=1 returns the FSM to IDLE.
REQ-030 Interrupt: status_i='h0000_0401, cause_i='h0000_0400, mem_valid_i=1, break_i=1 -> excepttype_o=1. The same stimulus with status_i[1]=1 -> excepttype_o=9.
REQ-031 Reset mid-redirect: rst=1 pulsed for 1 cycle during REDIRECT -> newpc_valid_o=0 and flush_o=0 from the next cycle; ri_i=1 during REDIRECT never produces 'h0a.
